// File: rtl/vscale_hasti_sram_slave_if.sv
// AHB-lite (HASTI) bus bundle between one master and the SRAM slave.
// Address-phase controls, write data and the slave response travel together here.
interface vscale_hasti_sram_slave_if;
    parameter int HASTI_ADDR_WIDTH  = 32;
    parameter int HASTI_BUS_WIDTH   = 32;
    parameter int HASTI_SIZE_WIDTH  = 3;
    parameter int HASTI_TRANS_WIDTH = 2;
    parameter int HASTI_BURST_WIDTH = 3;
    parameter int HASTI_PROT_WIDTH  = 4;
    parameter int HASTI_RESP_WIDTH  = 1;

    logic                         hsel;
    logic [HASTI_ADDR_WIDTH-1:0]  haddr;
    logic                         hwrite;
    logic [HASTI_SIZE_WIDTH-1:0]  hsize;
    logic [HASTI_TRANS_WIDTH-1:0] htrans;
    logic [HASTI_BURST_WIDTH-1:0] hburst;
    logic                         hmastlock;
    logic [HASTI_PROT_WIDTH-1:0]  hprot;
    logic [HASTI_BUS_WIDTH-1:0]   hwdata;
    logic [HASTI_BUS_WIDTH-1:0]   hrdata;
    logic                         hready;
    logic [HASTI_RESP_WIDTH-1:0]  hresp;

    modport master (
        output hsel, haddr, hwrite, hsize, htrans, hburst, hmastlock, hprot, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  hsel, haddr, hwrite, hsize, htrans, hburst, hmastlock, hprot, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/vscale_hasti_sram_slave.sv
// Word-organised SRAM behind an AHB-lite slave port with configurable data-phase
// wait states and a two-cycle ERROR response for out-of-range or misaligned accesses.
module vscale_hasti_sram_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    vscale_hasti_sram_slave_if.slave        bus
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_STATES);
    localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      wait_q, wait_d;
    logic [AW-1:0]   widx_q, widx_d;
    logic [1:0]      boff_q, boff_d;
    logic [2:0]      size_q, size_d;
    logic            write_q, write_d;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [31:0]     offset_s;
    logic            illegal_s;
    logic            accept_s;
    logic            hready_s;
    logic            hresp_s;
    logic [31:0]     hrdata_s;
    logic            mem_we_s;
    logic [3:0]      wmask_s;
    logic            unused_s;

    function automatic logic [3:0] lane_mask_f(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << off;
            3'd1:    m = off[1] ? 4'b1100 : 4'b0011;
            3'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    assign offset_s  = bus.haddr - BASE_ADDR;
    assign illegal_s = (bus.haddr < BASE_ADDR)
                    || ((offset_s >> 2) >= DEPTH_W32)
                    || (bus.hsize > 3'd2)
                    || ((bus.hsize == 3'd1) && bus.haddr[0])
                    || ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
    assign accept_s  = hready_s && bus.hsel && bus.htrans[1];
    assign wmask_s   = lane_mask_f(size_q, boff_q);
    assign unused_s  = ^{bus.hburst, bus.hmastlock, bus.hprot, offset_s[31:AW+2], offset_s[1:0]};

    // Next-state, response and memory-enable decode
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        widx_d   = widx_q;
        boff_d   = boff_q;
        size_d   = size_q;
        write_d  = write_q;
        hready_s = 1'b1;
        hresp_s  = 1'b0;
        hrdata_s = 32'h0000_0000;
        mem_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hready_s = 1'b1;
            end
            ST_DATA: begin
                if (wait_q != 3'd0) begin
                    hready_s = 1'b0;
                    wait_d   = wait_q - 3'd1;
                end else begin
                    hready_s = 1'b1;
                    state_d  = ST_IDLE;
                    if (write_q) begin
                        mem_we_s = 1'b1;
                    end else begin
                        hrdata_s = mem[widx_q];
                    end
                end
            end
            ST_ERR1: begin
                hready_s = 1'b0;
                hresp_s  = 1'b1;
                state_d  = ST_ERR2;
            end
            ST_ERR2: begin
                hready_s = 1'b1;
                hresp_s  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A completing cycle doubles as the next address phase, so no bubble
        if (accept_s) begin
            state_d = illegal_s ? ST_ERR1 : ST_DATA;
            wait_d  = WAIT_INIT;
            widx_d  = offset_s[AW+1:2];
            boff_d  = bus.haddr[1:0];
            size_d  = bus.hsize;
            write_d = bus.hwrite;
        end else begin
            state_d = state_d;
        end
    end

    // State and captured address-phase controls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            wait_q  <= 3'd0;
            widx_q  <= '0;
            boff_q  <= 2'd0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            widx_q  <= widx_d;
            boff_q  <= boff_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    // Byte-lane write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we_s && wmask_s[b]) begin
                mem[widx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
            end
        end
    end

    assign bus.hready = hready_s;
    assign bus.hresp  = hresp_s;
    assign bus.hrdata = hrdata_s;

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Randomised bench: three slaves (0, 2 and 3 wait states) driven by a pipelined
// master and compared against a byte-array memory model with AHB response rules.
module tb_vscale_hasti_sram_slave;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          NI    = 3;

    typedef struct {
        logic        hsel;
        logic [1:0]  htrans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk;
    logic        rst_n_a     [NI];
    logic        hsel_a      [NI];
    logic [31:0] haddr_a     [NI];
    logic        hwrite_a    [NI];
    logic [2:0]  hsize_a     [NI];
    logic [1:0]  htrans_a    [NI];
    logic [2:0]  hburst_a    [NI];
    logic        hmastlock_a [NI];
    logic [3:0]  hprot_a     [NI];
    logic [31:0] hwdata_a    [NI];
    logic [31:0] hrdata_a    [NI];
    logic        hready_a    [NI];
    logic        hresp_a     [NI];

    logic [7:0]  mem_m [NI][4*DEPTH];
    xfer_t       seq[$];
    int          n_chk = 0;
    int          n_err = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        vscale_hasti_sram_slave_if bus ();
        assign bus.hsel      = hsel_a[g];
        assign bus.haddr     = haddr_a[g];
        assign bus.hwrite    = hwrite_a[g];
        assign bus.hsize     = hsize_a[g];
        assign bus.htrans    = htrans_a[g];
        assign bus.hburst    = hburst_a[g];
        assign bus.hmastlock = hmastlock_a[g];
        assign bus.hprot     = hprot_a[g];
        assign bus.hwdata    = hwdata_a[g];
        assign hrdata_a[g]   = bus.hrdata;
        assign hready_a[g]   = bus.hready;
        assign hresp_a[g]    = bus.hresp;
        vscale_hasti_sram_slave #(
            .DEPTH_WORDS (DEPTH),
            .BASE_ADDR   (BASE),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .clk     (clk),
            .reset_n (rst_n_a[g]),
            .bus     (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws_of(input int inst);
        return (inst == 0) ? 0 : ((inst == 1) ? 2 : 3);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit active_f(input xfer_t x);
        return x.hsel && x.htrans[1];
    endfunction

    function automatic bit err_f(input xfer_t x);
        longint off;
        off = longint'(x.addr) - longint'(BASE);
        if (off < 0) return 1'b1;
        if (off >= longint'(4 * DEPTH)) return 1'b1;
        if (x.size > 3'd2) return 1'b1;
        if ((x.addr % (32'd1 << x.size)) != 32'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input int inst, input logic [31:0] addr);
        int wb;
        wb = int'((addr - BASE) & ~32'd3);
        return {mem_m[inst][wb+3], mem_m[inst][wb+2], mem_m[inst][wb+1], mem_m[inst][wb]};
    endfunction

    task automatic model_write(input int inst, input xfer_t x);
        int wb;
        int lane;
        wb = int'((x.addr - BASE) & ~32'd3);
        for (int k = 0; k < (1 << x.size); k++) begin
            lane = int'(x.addr[1:0]) + k;
            mem_m[inst][wb+lane] = x.wdata[8*lane +: 8];
        end
    endtask

    task automatic add_x(input logic hsel, input logic [1:0] htrans, input logic wr,
                         input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        xfer_t x;
        x.hsel = hsel; x.htrans = htrans; x.wr = wr;
        x.addr = addr; x.size = size; x.wdata = wdata;
        seq.push_back(x);
    endtask

    task automatic add_w(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        add_x(1'b1, 2'd2, 1'b1, addr, size, wdata);
    endtask

    task automatic add_r(input logic [31:0] addr, input logic [2:0] size);
        add_x(1'b1, 2'd2, 1'b0, addr, size, $urandom);
    endtask

    task automatic add_rand();
        int r;
        int sz;
        logic [31:0] a;
        r  = $urandom_range(0, 99);
        sz = $urandom_range(0, 9);
        sz = (sz < 3) ? 0 : ((sz < 6) ? 1 : ((sz < 9) ? 2 : 3));
        if ($urandom_range(0, 9) == 0) begin
            a = BASE - 32'd16 + 32'($urandom_range(0, 4 * DEPTH + 31));
        end else begin
            a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
        end
        if ($urandom_range(0, 9) != 0) begin
            a = a & ~((32'd1 << ((sz > 2) ? 2 : sz)) - 32'd1);
        end
        if (r < 5) begin
            add_x(1'b0, 2'($urandom_range(2, 3)), 1'($urandom), a, 3'(sz), $urandom);
        end else if (r < 10) begin
            add_x(1'b1, 2'($urandom_range(0, 1)), 1'($urandom), a, 3'(sz), $urandom);
        end else begin
            add_x(1'b1, 2'($urandom_range(2, 3)), 1'($urandom), a, 3'(sz), $urandom);
        end
    endtask

    task automatic drive_ap(input int inst, input xfer_t x);
        hsel_a[inst]      = x.hsel;
        htrans_a[inst]    = x.htrans;
        hwrite_a[inst]    = x.wr;
        haddr_a[inst]     = x.addr;
        hsize_a[inst]     = x.size;
        hburst_a[inst]    = 3'($urandom);
        hmastlock_a[inst] = 1'($urandom);
        hprot_a[inst]     = 4'($urandom);
    endtask

    task automatic drive_idle(input int inst);
        hsel_a[inst]      = 1'b0;
        htrans_a[inst]    = 2'd0;
        hwrite_a[inst]    = 1'($urandom);
        haddr_a[inst]     = $urandom;
        hsize_a[inst]     = 3'd2;
        hburst_a[inst]    = 3'd0;
        hmastlock_a[inst] = 1'b0;
        hprot_a[inst]     = 4'd0;
    endtask

    // Pipelined master: issues seq back-to-back and checks every data phase
    task automatic run_seq(input int inst, output int dcycles, output logic [31:0] last_rd);
        int ai, dp, low, budget, n, exp_low;
        bit act, err;
        xfer_t x;
        logic [31:0] exp_rd;
        n = seq.size(); ai = 0; dp = -1; low = 0; dcycles = 0; budget = 0;
        last_rd = 32'h0;
        while ((ai < n || dp >= 0) && budget < 4000) begin
            @(negedge clk);
            budget++;
            if (dp >= 0) begin
                x = seq[dp];
                act = active_f(x);
                err = act && err_f(x);
                dcycles++;
                hwdata_a[inst] = x.wr ? x.wdata : $urandom;
                if (hready_a[inst] == 1'b0) begin
                    low++;
                    check_eq("resp_wait", 32'(hresp_a[inst]), 32'(err));
                    check_eq("rdata_wait", hrdata_a[inst], 32'h0);
                end else begin
                    exp_low = !act ? 0 : (err ? 1 : ws_of(inst));
                    check_eq("wait_cycles", 32'(low), 32'(exp_low));
                    check_eq("resp_done", 32'(hresp_a[inst]), 32'(err));
                    exp_rd = (act && !err && !x.wr) ? model_read(inst, x.addr) : 32'h0;
                    check_eq("rdata", hrdata_a[inst], exp_rd);
                    if (act && !err && !x.wr) last_rd = hrdata_a[inst];
                    if (act && !err && x.wr) model_write(inst, x);
                    dp = -1;
                    low = 0;
                end
            end
            if (hready_a[inst]) begin
                if (ai < n) begin
                    drive_ap(inst, seq[ai]);
                    dp = ai;
                    ai++;
                end else begin
                    drive_idle(inst);
                end
            end
        end
        check_eq("seq_done", 32'(ai == n && dp < 0), 32'd1);
        seq.delete();
    endtask

    initial begin
        int dc;
        logic [31:0] rd;
        for (int i = 0; i < NI; i++) begin
            rst_n_a[i] = 1'b0;
            hwdata_a[i] = 32'h0;
            drive_idle(i);
        end
        #3;
        for (int i = 0; i < NI; i++) begin
            check_eq("rst_hready", 32'(hready_a[i]), 32'd1);
            check_eq("rst_hresp", 32'(hresp_a[i]), 32'd0);
            check_eq("rst_hrdata", hrdata_a[i], 32'h0);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) rst_n_a[i] = 1'b1;

        for (int i = 0; i < NI; i++) begin
            for (int w = 0; w < DEPTH; w++) add_w(BASE + 32'(4 * w), 3'd2, $urandom);
            run_seq(i, dc, rd);
        end

        add_w(BASE + 32'h10, 3'd2, 32'hDEAD_BEEF);
        add_r(BASE + 32'h10, 3'd2);
        run_seq(0, dc, rd);
        check_eq("ws0_pair_cycles", 32'(dc), 32'd2);
        check_eq("deadbeef", rd, 32'hDEAD_BEEF);

        add_w(BASE + 32'h20, 3'd2, 32'h1122_3344);
        add_w(BASE + 32'h23, 3'd0, 32'hAA00_0000);
        add_w(BASE + 32'h20, 3'd1, 32'h0000_5566);
        add_r(BASE + 32'h20, 3'd2);
        run_seq(0, dc, rd);
        check_eq("byte_lanes", rd, 32'hAA22_5566);

        add_w(BASE, 3'd2, 32'h0BAD_F00D);
        add_r(BASE + 32'(4 * DEPTH), 3'd2);
        add_w(BASE + 32'h2, 3'd2, 32'h1234_5678);
        add_w(BASE - 32'h4, 3'd2, 32'h8765_4321);
        add_r(BASE + 32'h1, 3'd1);
        add_w(BASE, 3'd3, 32'hFFFF_FFFF);
        add_r(BASE, 3'd2);
        run_seq(0, dc, rd);
        check_eq("err_mem_kept", rd, 32'h0BAD_F00D);

        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 150; k++) add_rand();
            run_seq(i, dc, rd);
        end

        add_r(BASE + 32'h10, 3'd2);
        run_seq(1, dc, rd);
        check_eq("ws2_single_cycles", 32'(dc), 32'd3);
        add_r(BASE + 32'h10, 3'd2);
        add_r(BASE + 32'h14, 3'd2);
        run_seq(1, dc, rd);
        check_eq("ws2_pair_cycles", 32'(dc), 32'd6);

        add_w(BASE + 32'h40, 3'd2, 32'h0000_0000);
        run_seq(2, dc, rd);
        @(negedge clk);
        add_w(BASE + 32'h40, 3'd2, 32'hCAFE_F00D);
        drive_ap(2, seq[0]);
        seq.delete();
        @(negedge clk);
        hwdata_a[2] = 32'hCAFE_F00D;
        drive_idle(2);
        check_eq("abort_in_wait", 32'(hready_a[2]), 32'd0);
        @(posedge clk);
        #2;
        rst_n_a[2] = 1'b0;
        #1;
        check_eq("async_hready", 32'(hready_a[2]), 32'd1);
        check_eq("async_hresp", 32'(hresp_a[2]), 32'd0);
        check_eq("async_hrdata", hrdata_a[2], 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n_a[2] = 1'b1;
        add_r(BASE + 32'h40, 3'd2);
        run_seq(2, dc, rd);
        check_eq("abort_no_write", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
